vga_color_driver: RTL and testbench



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_timing.sv | 62 ++++++
 rtl/vga_color_driver.sv | 120 ++++++++++++
 tb/tb_vga_color_driver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, sync window bounds, colour-mode encodings and
// level thresholds for the colour test-pattern driver.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef enum logic [2:0] {
    MODE_GRID  = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_GREY  = 3'd4,
    MODE_WHITE = 3'd5
  } mode_e;

  localparam logic [CNT_W-1:0] HL_T1 = 10'd160;
  localparam logic [CNT_W-1:0] HL_T2 = 10'd320;
  localparam logic [CNT_W-1:0] HL_T3 = 10'd480;
  localparam logic [CNT_W-1:0] VL_T1 = 10'd120;
  localparam logic [CNT_W-1:0] VL_T2 = 10'd240;
  localparam logic [CNT_W-1:0] VL_T3 = 10'd360;

  function automatic logic [1:0] level(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] t1,
                                       input logic [CNT_W-1:0] t2,
                                       input logic [CNT_W-1:0] t3);
    logic [1:0] l;
    if (c < t1)      l = 2'd0;
    else if (c < t2) l = 2'd1;
    else if (c < t3) l = 2'd2;
    else             l = 2'd3;
    return l;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical counters; produces the active
// window and unregistered active-low sync levels for the current position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             active,
  output logic             hsync_raw,
  output logic             vsync_raw
);

  localparam logic [2:0]       DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [2:0] div;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= tick ? 3'd0 : div + 3'd1;
      if (tick) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  assign active    = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_raw = !((hcount >= H_SS) && (hcount <= H_SE));
  assign vsync_raw = !((vcount >= V_SS) && (vcount <= V_SE));

endmodule

// File: rtl/vga_color_driver.sv
// 640x480 VGA RGB222 test-pattern driver with a once-per-frame mode latch.
// Optional build macro VGA_BORDER_EN paints a white frame around the active area.
module vga_color_driver
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [2:0] ColorSel,
  output logic       Hsync,
  output logic       Vsync,
  output logic [1:0] Red,
  output logic [1:0] Green,
  output logic [1:0] Blue
);

  localparam logic [CNT_W-1:0] V_LATCH = CNT_W'(V_ACTIVE);
`ifdef VGA_BORDER_EN
  localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_ACTIVE - 1);
`endif

  logic             tick;
  logic             active;
  logic             hsync_raw;
  logic             vsync_raw;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic [2:0]       mode_reg;
  logic [1:0]       hl;
  logic [1:0]       vl;
  logic [1:0]       red_p0;
  logic [1:0]       green_p0;
  logic [1:0]       blue_p0;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk      (Clk),
    .reset    (reset),
    .tick     (tick),
    .hcount   (hcount),
    .vcount   (vcount),
    .active   (active),
    .hsync_raw(hsync_raw),
    .vsync_raw(vsync_raw)
  );

  assign hl = level(hcount, HL_T1, HL_T2, HL_T3);
  assign vl = level(vcount, VL_T1, VL_T2, VL_T3);

  // Stage p0: colour for the current counter position
  always_comb begin
    red_p0   = 2'd0;
    green_p0 = 2'd0;
    blue_p0  = 2'd0;
    if (active) begin
      case (mode_reg)
        MODE_GRID: begin
          red_p0   = hl;
          green_p0 = vl;
          blue_p0  = {hcount[5], vcount[5]};
        end
        MODE_RED:   red_p0   = hl;
        MODE_GREEN: green_p0 = hl;
        MODE_BLUE:  blue_p0  = hl;
        MODE_GREY: begin
          red_p0   = hl;
          green_p0 = hl;
          blue_p0  = hl;
        end
        MODE_WHITE: begin
          red_p0   = 2'd3;
          green_p0 = 2'd3;
          blue_p0  = 2'd3;
        end
        default: ;
      endcase
`ifdef VGA_BORDER_EN
      if (hcount == '0 || hcount == H_EDGE || vcount == '0 || vcount == V_EDGE) begin
        red_p0   = 2'd3;
        green_p0 = 2'd3;
        blue_p0  = 2'd3;
      end
`endif
    end
  end

  // Stage p1: registered outputs; mode latched in vertical blanking so frames never tear
  always_ff @(posedge Clk) begin
    if (reset) begin
      mode_reg <= MODE_GRID;
      Hsync    <= 1'b1;
      Vsync    <= 1'b1;
      Red      <= 2'd0;
      Green    <= 2'd0;
      Blue     <= 2'd0;
    end else if (tick) begin
      if (hcount == '0 && vcount == V_LATCH)
        mode_reg <= ColorSel;
      Hsync <= hsync_raw;
      Vsync <= vsync_raw;
      Red   <= red_p0;
      Green <= green_p0;
      Blue  <= blue_p0;
    end
  end

endmodule

// File: tb/tb_vga_color_driver.sv
// Directed bench for vga_color_driver with a shortened vertical frame
// (4 active lines, 8 total) so several frames fit in a short run.
module tb_vga_color_driver;

  localparam int LINE  = 800;
  localparam int FRAME = 8 * LINE;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset;
  logic [2:0] ColorSel;
  logic       Hsync;
  logic       Vsync;
  logic [1:0] Red;
  logic [1:0] Green;
  logic [1:0] Blue;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  vga_color_driver #(
    .CLK_DIV (2),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4),   .V_FP(1),  .V_SYNC(2),  .V_BP(1)
  ) dut (
    .Clk     (Clk),
    .reset   (reset),
    .ColorSel(ColorSel),
    .Hsync   (Hsync),
    .Vsync   (Vsync),
    .Red     (Red),
    .Green   (Green),
    .Blue    (Blue)
  );

  always #5 Clk = ~Clk;

  // Clk edge (counted from reset release) on which pixel (x,y) of frame f is registered.
  function automatic int pe(input int f, input int y, input int x);
    return 2 * (f * FRAME + y * LINE + x + 1);
  endfunction

  function automatic logic [5:0] bsel(input logic [5:0] plain);
    return BORDER ? 6'h3F : plain;
  endfunction

  task automatic goto_edge(input int e);
    while (edges < e) begin
      @(posedge Clk);
      edges++;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input int f, input int y, input int x,
                         input logic [5:0] exp);
    goto_edge(pe(f, y, x));
    check(tag, {2'b00, Red, Green, Blue}, {2'b00, exp});
  endtask

  task automatic chk_hs(input string tag, input int f, input int y, input int x,
                        input logic exp);
    goto_edge(pe(f, y, x));
    check(tag, {7'd0, Hsync}, {7'd0, exp});
  endtask

  task automatic chk_vs(input string tag, input int f, input int y, input int x,
                        input logic exp);
    goto_edge(pe(f, y, x));
    check(tag, {7'd0, Vsync}, {7'd0, exp});
  endtask

  initial begin
    reset    = 1'b1;
    ColorSel = 3'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_state", {Hsync, Vsync, Red, Green, Blue}, 8'b1100_0000);
    reset    = 1'b0;
    edges    = 0;
    ColorSel = 3'd1;

    // Frame 0: grid pattern, horizontal and vertical sync windows
    chk_rgb("f0_px0_0",      0, 0, 0,   bsel(6'b000000));
    chk_hs ("hs_655_high",   0, 0, 655, 1'b1);
    chk_hs ("hs_656_low",    0, 0, 656, 1'b0);
    chk_hs ("hs_751_low",    0, 0, 751, 1'b0);
    chk_hs ("hs_752_high",   0, 0, 752, 1'b1);
    chk_rgb("grid_100_1",    0, 1, 100, 6'b000010);
    chk_hs ("hs_l1_655",     0, 1, 655, 1'b1);
    chk_hs ("hs_l1_656",     0, 1, 656, 1'b0);
    chk_rgb("grid_200_2",    0, 2, 200, 6'b010000);
    chk_rgb("grid_500_2",    0, 2, 500, 6'b110010);
    chk_vs ("vs_l4_high",    0, 4, 799, 1'b1);
    chk_vs ("vs_l5_low",     0, 5, 0,   1'b0);
    chk_vs ("vs_l6_low",     0, 6, 799, 1'b0);
    chk_vs ("vs_l7_high",    0, 7, 0,   1'b1);

    // Frame 1: red ramp latched from ColorSel=1
    chk_rgb("red_0",   1, 2, 0,   bsel(6'b000000));
    chk_rgb("red_159", 1, 2, 159, 6'b000000);
    chk_rgb("red_160", 1, 2, 160, 6'b010000);
    chk_rgb("red_319", 1, 2, 319, 6'b010000);
    chk_rgb("red_320", 1, 2, 320, 6'b100000);
    chk_rgb("red_479", 1, 2, 479, 6'b100000);
    chk_rgb("red_480", 1, 2, 480, 6'b110000);
    chk_rgb("red_639", 1, 2, 639, bsel(6'b110000));
    chk_rgb("red_640", 1, 2, 640, 6'b000000);
    chk_rgb("red_799", 1, 2, 799, 6'b000000);
    ColorSel = 3'd4;
    chk_rgb("red_held", 1, 3, 400, 6'b100000);
    chk_vs ("vs_f1_low", 1, 5, 0, 1'b0);

    // Frame 2: grey ramp; switch to white mid-frame must not tear
    chk_rgb("grey_400_1", 2, 1, 400, 6'b101010);
    ColorSel = 3'd5;
    chk_rgb("grey_200_2", 2, 2, 200, 6'b010101);
    chk_rgb("grey_400_2", 2, 2, 400, 6'b101010);

    // Frame 3: white; ColorSel changed just before and just after the latch tick
    chk_rgb("white_100_1", 3, 1, 100, 6'b111111);
    chk_rgb("white_blank", 3, 1, 700, 6'b000000);
    goto_edge(pe(3, 4, 0) - 1);
    ColorSel = 3'd6;
    goto_edge(pe(3, 4, 0));
    ColorSel = 3'd2;

    // Frame 4: black (mode 6), border pixels depend on build
    chk_rgb("black_0_0",   4, 0, 0,   bsel(6'b000000));
    chk_rgb("black_400_1", 4, 1, 400, 6'b000000);
    chk_rgb("black_639_3", 4, 3, 639, bsel(6'b000000));

    // Mid-frame reset while both syncs are low
    goto_edge(pe(4, 5, 700));
    check("pre_reset_sync", {6'd0, Hsync, Vsync}, 8'b0000_0000);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    check("mid_reset_state", {Hsync, Vsync, Red, Green, Blue}, 8'b1100_0000);
    reset = 1'b0;
    edges = 0;
    chk_hs ("rst_hs_655", 0, 0, 655, 1'b1);
    chk_hs ("rst_hs_656", 0, 0, 656, 1'b0);
    chk_rgb("rst_grid",   0, 1, 100, 6'b000010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
